ex_mem_reg: RTL

- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures the EX result bundle: GPR write address/enable/data and HI/LO write request with values.
- Applies the global stall vector and the exception flush to that bundle.
- Holds the 64-bit intermediate product and 2-bit cycle count so that two-cycle EX operations (MADD/MSUB class) can feed them back into EX while EX is stalled.

---
 rtl/ex_mem_if.sv | 37 +++
 rtl/ex_mem_reg.sv | 96 +++++++++
 2 files changed

// File: rtl/ex_mem_if.sv
// EX -> MEM pipeline bundle: EX-side result signals and the registered
// MEM-side copy, plus the multi-cycle feedback path back into EX.
interface ex_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   ex_waddr;
  logic                ex_we;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_whilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [2*DATA_W-1:0] ex_hilo_temp;
  logic [1:0]          ex_cnt;

  logic [ADDR_W-1:0]   mem_waddr;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_whilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic                mem_valid;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [1:0]          cnt_o;

  modport master (
    output ex_waddr, ex_we, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_hilo_temp, ex_cnt,
    input  mem_waddr, mem_we, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_valid,
    input  hilo_temp_o, cnt_o
  );

  modport slave (
    input  ex_waddr, ex_we, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_hilo_temp, ex_cnt,
    output mem_waddr, mem_we, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_valid,
    output hilo_temp_o, cnt_o
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush handling, multi-cycle MADD/MSUB
// feedback storage and saturating stall/bubble statistics counters.
module ex_mem_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  ex_mem_if.slave            bus,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);
  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              valid;
  } mem_bundle_t;

  mem_bundle_t         mem_d, mem_q, ex_bundle;
  logic [2*DATA_W-1:0] hilo_temp_d, hilo_temp_q;
  logic [1:0]          cnt_d, cnt_q;
  logic [CNT_W-1:0]    stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0]    bubble_cnt_d, bubble_cnt_q;
  logic                ex_stall, mem_stall, unused_stall;

  assign ex_stall     = stall[3];
  assign mem_stall    = stall[4];
  assign unused_stall = ^stall;

  assign ex_bundle = '{waddr: bus.ex_waddr, we: bus.ex_we, wdata: bus.ex_wdata,
                       whilo: bus.ex_whilo, hi: bus.ex_hi, lo: bus.ex_lo, valid: 1'b1};

  always_comb begin
    mem_d        = mem_q;
    hilo_temp_d  = hilo_temp_q;
    cnt_d        = cnt_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      mem_d       = '0;
      hilo_temp_d = '0;
      cnt_d       = '0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (mem_stall) begin
      // MEM stalled (with or without EX): hold; EX may still be iterating
      hilo_temp_d = bus.ex_hilo_temp;
      cnt_d       = bus.ex_cnt;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (ex_stall) begin
      mem_d       = '0;
      hilo_temp_d = bus.ex_hilo_temp;
      cnt_d       = bus.ex_cnt;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else begin
      mem_d       = ex_bundle;
      hilo_temp_d = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q        <= '0;
      hilo_temp_q  <= '0;
      cnt_q        <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      mem_q        <= mem_d;
      hilo_temp_q  <= hilo_temp_d;
      cnt_q        <= cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.mem_waddr   = mem_q.waddr;
  assign bus.mem_we      = mem_q.we;
  assign bus.mem_wdata   = mem_q.wdata;
  assign bus.mem_whilo   = mem_q.whilo;
  assign bus.mem_hi      = mem_q.hi;
  assign bus.mem_lo      = mem_q.lo;
  assign bus.mem_valid   = mem_q.valid;
  assign bus.hilo_temp_o = hilo_temp_q;
  assign bus.cnt_o       = cnt_q;
  assign stall_cnt       = stall_cnt_q;
  assign bubble_cnt      = bubble_cnt_q;
endmodule
